// File: rtl/tc0_counter.sv
// tc0_counter: timer/counter with prescaled or external-pin tick, CTC mode, compare output and CPU-clearable flags
module tc0_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk8en,
    input  logic             clk64en,
    input  logic             clk256en,
    input  logic             clk1024en,
    input  logic             t0_pin,
    input  logic [2:0]       cs,
    input  logic             ctc,
    input  logic [1:0]       com,
    input  logic [WIDTH-1:0] ocr,
    input  logic             tcnt_wr,
    input  logic [WIDTH-1:0] tcnt_wdata,
    input  logic             tov_clr,
    input  logic             ocf_clr,
    output logic [WIDTH-1:0] tcnt,
    output logic             tov,
    output logic             ocf,
    output logic             oc
);
    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] tcnt_q, tcnt_d;
    logic             tov_q, tov_d, ocf_q, ocf_d, oc_q, oc_d, blk_q, blk_d;
    logic             sync1_q, sync2_q, hist_q;
    logic             tick, at_ocr, at_max, match, ovf;

    // Pin synchronizer and edge history run whatever cs is, so selecting a pin source never sees a stale edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= t0_pin;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    // Tick selection, write priority over counting, compare/overflow detection, flag and OC next state
    always_comb begin
        case (cs)
            3'b000:  tick = 1'b0;
            3'b001:  tick = 1'b1;
            3'b010:  tick = clk8en;
            3'b011:  tick = clk64en;
            3'b100:  tick = clk256en;
            3'b101:  tick = clk1024en;
            3'b110:  tick = hist_q & ~sync2_q;
            default: tick = sync2_q & ~hist_q;
        endcase
        at_ocr = tcnt_q == ocr;
        at_max = tcnt_q == MAX;
        match  = tick & ~tcnt_wr & ~blk_q & at_ocr;
        ovf    = tick & ~tcnt_wr & at_max;
        tcnt_d = tcnt_wr ? tcnt_wdata : !tick ? tcnt_q : (ctc && at_ocr) ? '0 : tcnt_q + 1'b1;
        blk_d  = tcnt_wr | (blk_q & ~tick);
        tov_d  = ovf | (tov_q & ~tov_clr);
        ocf_d  = match | (ocf_q & ~ocf_clr);
        oc_d   = (com == 2'b00) ? 1'b0 : !match ? oc_q : (com == 2'b01) ? ~oc_q : com[0];
    end

    // Counter, flags, compare output and post-write blocking flag
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q <= '0;
            tov_q  <= 1'b0;
            ocf_q  <= 1'b0;
            oc_q   <= 1'b0;
            blk_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tov_q  <= tov_d;
            ocf_q  <= ocf_d;
            oc_q   <= oc_d;
            blk_q  <= blk_d;
        end
    end

    assign tcnt = tcnt_q;
    assign tov  = tov_q;
    assign ocf  = ocf_q;
    assign oc   = oc_q;
endmodule

// File: tb/tb_tc0_counter.sv
// tb_tc0_counter: randomized and directed checks of tc0_counter against a behavioural timer model
module tb_tc0_counter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk8en = 0, clk64en = 0, clk256en = 0, clk1024en = 0, t0_pin = 0;
    logic [2:0] cs = 0;
    logic       ctc = 0;
    logic [1:0] com = 0;
    logic [7:0] ocr = 0;
    logic       tcnt_wr = 0;
    logic [7:0] tcnt_wdata = 0;
    logic       tov_clr = 0, ocf_clr = 0;
    logic [7:0] tcnt;
    logic       tov, ocf, oc;
    logic [10:0] dut_vec;

    int n_checks = 0;
    int n_fail = 0;

    int       m_cnt;
    bit       m_tov, m_ocf, m_oc, m_skip;
    bit [2:0] ph;

    tc0_counter #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .clk8en(clk8en), .clk64en(clk64en), .clk256en(clk256en),
        .clk1024en(clk1024en), .t0_pin(t0_pin), .cs(cs), .ctc(ctc), .com(com), .ocr(ocr),
        .tcnt_wr(tcnt_wr), .tcnt_wdata(tcnt_wdata), .tov_clr(tov_clr), .ocf_clr(ocf_clr),
        .tcnt(tcnt), .tov(tov), .ocf(ocf), .oc(oc)
    );

    always #5 clk = ~clk;
    assign dut_vec = {tcnt, tov, ocf, oc};

    function automatic logic [10:0] model_vec();
        return {8'(m_cnt), m_tov, m_ocf, m_oc};
    endfunction

    // Advance the model by one clock edge from the current inputs, then clock the DUT
    task automatic step();
        bit tk, mt, ov;
        if (reset) begin
            m_cnt = 0; m_tov = 0; m_ocf = 0; m_oc = 0; m_skip = 0; ph = 3'b000;
        end else begin
            case (cs)
                3'd0: tk = 0;
                3'd1: tk = 1;
                3'd2: tk = clk8en;
                3'd3: tk = clk64en;
                3'd4: tk = clk256en;
                3'd5: tk = clk1024en;
                3'd6: tk = ph[2] && !ph[1];
                default: tk = !ph[2] && ph[1];
            endcase
            mt = 0;
            ov = 0;
            if (tcnt_wr) begin
                m_cnt = int'(tcnt_wdata);
                m_skip = 1;
            end else if (tk) begin
                mt = (m_cnt == int'(ocr)) && !m_skip;
                ov = m_cnt == 255;
                m_cnt = (ctc && m_cnt == int'(ocr)) ? 0 : (m_cnt + 1) % 256;
                m_skip = 0;
            end
            m_tov = ov || (m_tov && !tov_clr);
            m_ocf = mt || (m_ocf && !ocf_clr);
            if (com == 2'b00) m_oc = 0;
            else if (mt) m_oc = (com == 2'b01) ? !m_oc : (com == 2'b11);
            ph = {ph[1:0], t0_pin};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        {clk8en, clk64en, clk256en, clk1024en, tcnt_wr, tov_clr, ocf_clr} = '0;
        tcnt_wdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        cs = 3'b001; tcnt_wr = 1; tcnt_wdata = 8'h5A; com = 2'b11; t0_pin = 1;
        reset = 1;
        step();
        step();
        n_checks++;
        if (dut_vec !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_state got %h want 000", dut_vec);
        end
        reset = 0;
        idle_inputs();
        t0_pin = 0; cs = 0; com = 0;
        step();
        n_checks++;
        if (dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL reset_hold got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_free_run();
        do_reset();
        cs = 3'b001; ctc = 0; ocr = 8'h10; com = 2'b00;
        for (int e = 1; e <= 256; e++) begin
            step();
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL free_run edge %0d got %h want %h", e, dut_vec, model_vec());
            end
            n_checks++;
            if ({tov, ocf} !== {e >= 256, e >= 17}) begin
                n_fail++;
                $display("FAIL free_run_flags edge %0d got tov=%b ocf=%b want tov=%b ocf=%b", e, tov, ocf, e >= 256, e >= 17);
            end
        end
        n_checks++;
        if (tcnt !== 8'h00) begin
            n_fail++;
            $display("FAIL free_run_wrap got %h want 00", tcnt);
        end
    endtask

    task automatic test_ctc();
        do_reset();
        cs = 3'b001; ctc = 1; ocr = 8'h04; com = 2'b01;
        for (int e = 1; e <= 22; e++) begin
            step();
            n_checks++;
            if (dut_vec !== {8'(e % 5), 1'b0, e >= 5, ((e / 5) % 2) == 1}) begin
                n_fail++;
                $display("FAIL ctc edge %0d got %h want %h", e, dut_vec, {8'(e % 5), 1'b0, e >= 5, ((e / 5) % 2) == 1});
            end
        end
    endtask

    task automatic test_ctc_max();
        do_reset();
        cs = 3'b001; ctc = 1; ocr = 8'hFF; com = 2'b11;
        tcnt_wr = 1; tcnt_wdata = 8'hFE;
        step();
        tcnt_wr = 0;
        step();
        step();
        n_checks++;
        if (dut_vec !== 11'b00000000_111) begin
            n_fail++;
            $display("FAIL ctc_max got %h want %h", dut_vec, 11'b00000000_111);
        end
    endtask

    task automatic test_prescale();
        do_reset();
        cs = 3'b011; ctc = 0; com = 2'b00; ocr = 8'h80;
        for (int c = 0; c < 256; c++) begin
            clk64en = (c % 64) == 63;
            step();
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL prescale cycle %0d got %h want %h", c, dut_vec, model_vec());
            end
        end
        clk64en = 0;
        n_checks++;
        if (tcnt !== 8'd4) begin
            n_fail++;
            $display("FAIL prescale_count got %0d want 4", tcnt);
        end
        cs = 3'b000;
        for (int c = 0; c < 40; c++) begin
            {clk8en, clk64en, clk256en, clk1024en} = 4'($urandom);
            t0_pin = 1'($urandom);
            step();
        end
        idle_inputs();
        t0_pin = 0;
        n_checks++;
        if (tcnt !== 8'd4) begin
            n_fail++;
            $display("FAIL stopped got %0d want 4", tcnt);
        end
    endtask

    task automatic test_t0();
        logic [7:0] want [14] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2};
        do_reset();
        cs = 3'b111; ctc = 0; com = 0; ocr = 8'h80; t0_pin = 0;
        repeat (3) step();
        t0_pin = 1;
        for (int i = 0; i < 14; i++) begin
            if (i == 5) t0_pin = 0;
            if (i == 9) cs = 3'b110;
            if (i == 10) t0_pin = 1;
            if (i == 11) t0_pin = 0;
            step();
            n_checks++;
            if (tcnt !== want[i]) begin
                n_fail++;
                $display("FAIL t0_edge step %0d got %0d want %0d", i, tcnt, want[i]);
            end
        end
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(3) == 0) t0_pin = ~t0_pin;
            if ($urandom_range(40) == 0) cs = 3'($urandom_range(7, 6));
            step();
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL t0_random cycle %0d got %h want %h", c, dut_vec, model_vec());
            end
        end
        t0_pin = 0;
    endtask

    task automatic test_write();
        do_reset();
        cs = 3'b001; ctc = 0; ocr = 8'h20; com = 2'b11;
        repeat (5) step();
        tcnt_wr = 1; tcnt_wdata = 8'h20;
        step();
        tcnt_wr = 0;
        n_checks++;
        if ({tcnt, ocf} !== {8'h20, 1'b0}) begin
            n_fail++;
            $display("FAIL write_load got tcnt=%h ocf=%b want tcnt=20 ocf=0", tcnt, ocf);
        end
        step();
        n_checks++;
        if (dut_vec !== {8'h21, 3'b000}) begin
            n_fail++;
            $display("FAIL write_block got %h want %h", dut_vec, {8'h21, 3'b000});
        end
        for (int j = 1; j <= 260; j++) begin
            step();
            n_checks++;
            if ({ocf, oc} !== {j >= 256, j >= 256} || dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL write_rematch tick %0d got %h want %h", j, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_flags();
        do_reset();
        cs = 3'b001; ctc = 0; ocr = 8'h00; com = 2'b00;
        tcnt_wr = 1; tcnt_wdata = 8'hFE;
        step();
        tcnt_wr = 0;
        step();
        tov_clr = 1;
        step();
        n_checks++;
        if ({tcnt, tov} !== {8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL tov_set_wins got tcnt=%h tov=%b want tcnt=00 tov=1", tcnt, tov);
        end
        ocf_clr = 1;
        step();
        n_checks++;
        if ({tov, ocf} !== 2'b01) begin
            n_fail++;
            $display("FAIL ocf_set_wins got tov=%b ocf=%b want tov=0 ocf=1", tov, ocf);
        end
        tov_clr = 0;
        step();
        n_checks++;
        if ({tcnt, ocf} !== {8'h02, 1'b0}) begin
            n_fail++;
            $display("FAIL ocf_clear got tcnt=%h ocf=%b want tcnt=02 ocf=0", tcnt, ocf);
        end
        ocf_clr = 0; com = 2'b01; ocr = 8'h05;
        repeat (4) step();
        n_checks++;
        if (dut_vec !== {8'h06, 3'b011}) begin
            n_fail++;
            $display("FAIL pre_abort got %h want %h", dut_vec, {8'h06, 3'b011});
        end
        reset = 1; tcnt_wr = 1; tcnt_wdata = 8'hFF;
        step();
        reset = 0;
        idle_inputs();
        n_checks++;
        if (dut_vec !== 11'h000) begin
            n_fail++;
            $display("FAIL mid_reset got %h want 000", dut_vec);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            reset = $urandom_range(299) == 0;
            if ($urandom_range(99) == 0) cs = 3'($urandom);
            if ($urandom_range(99) == 0) ctc = 1'($urandom);
            if ($urandom_range(63) == 0) com = 2'($urandom);
            if ($urandom_range(63) == 0) ocr = ($urandom_range(2) == 0) ? 8'hFF : 8'($urandom);
            {clk8en, clk64en, clk256en, clk1024en} = 4'($urandom) & 4'($urandom);
            if ($urandom_range(3) == 0) t0_pin = ~t0_pin;
            tcnt_wr = $urandom_range(39) == 0;
            tcnt_wdata = 8'($urandom);
            tov_clr = $urandom_range(15) == 0;
            ocf_clr = $urandom_range(15) == 0;
            step();
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL random cycle %0d got %h want %h", c, dut_vec, model_vec());
            end
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_ctc();
        test_ctc_max();
        test_prescale();
        test_t0();
        test_write();
        test_flags();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
